// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: word width, default instruction-memory geometry
// and the boot loader state encoding.
package mips_pkg;

   localparam int WORD_W      = 32;
   localparam int IMEM_ADDR_W = 10;
   localparam int IMEM_DEPTH  = 1024;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_RUN   = 3'd3,
      ST_ERROR = 3'd4
   } loader_state_t;

endpackage

// File: rtl/mips_imem_loader.sv
// Boot loader: streams program words into instruction memory from address 0,
// verifies a trailing 32-bit sum checksum, then releases the core.
//
// Handshake: a beat transfers on a rising clk1 edge where in_valid && in_ready;
// in_ready is registered and high only in LOAD, in_data/in_last must be stable
// while in_valid is high, and in_valid may drop between beats at any time.
module mips_imem_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int DEPTH  = IMEM_DEPTH
) (
   input  logic                clk1,
   input  logic                rst_n,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORD_W-1:0]   in_data,
   input  logic                in_last,
   output logic                mem_wr_en,
   output logic [ADDR_W-1:0]   mem_wr_addr,
   output logic [WORD_W-1:0]   mem_wr_data,
   output logic                core_run,
   output logic                done,
   output logic                error,
   output logic [ADDR_W:0]     word_count,
   output loader_state_t       dbg_state
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

   loader_state_t       state_q;
   logic                in_ready_q;
   logic                mem_wr_en_q;
   logic [ADDR_W-1:0]   mem_wr_addr_q;
   logic [WORD_W-1:0]   mem_wr_data_q;
   logic                core_run_q;
   logic                done_q;
   logic                error_q;
   logic [ADDR_W:0]     word_count_q;
   logic [WORD_W-1:0]   sum_q;
   logic [WORD_W-1:0]   chk_q;

   logic                accept_d;
   logic                room_d;
   logic [WORD_W-1:0]   sum_d;
   logic [ADDR_W:0]     word_count_d;

   always_comb begin
      accept_d     = in_valid && in_ready_q;
      room_d       = (word_count_q < DEPTH_C);
      sum_d        = sum_q + in_data;
      word_count_d = word_count_q + ONE_C;
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         in_ready_q    <= 1'b0;
         mem_wr_en_q   <= 1'b0;
         mem_wr_addr_q <= '0;
         mem_wr_data_q <= '0;
         core_run_q    <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         word_count_q  <= '0;
         sum_q         <= '0;
         chk_q         <= '0;
      end else begin
         mem_wr_en_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
               if (start) begin
                  state_q       <= ST_LOAD;
                  in_ready_q    <= 1'b1;
                  mem_wr_addr_q <= '0;
                  word_count_q  <= '0;
                  sum_q         <= '0;
                  core_run_q    <= 1'b0;
                  done_q        <= 1'b0;
                  error_q       <= 1'b0;
               end else if (state_q == ST_RUN) begin
                  // Flags follow the state by one edge, so a good load
                  // releases the core two edges after the checksum beat.
                  core_run_q <= 1'b1;
                  done_q     <= 1'b1;
               end else if (state_q == ST_ERROR) begin
                  error_q <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (accept_d) begin
                  if (in_last) begin
                     chk_q      <= in_data;
                     in_ready_q <= 1'b0;
                     state_q    <= ST_CHECK;
                  end else if (room_d) begin
                     mem_wr_en_q   <= 1'b1;
                     mem_wr_addr_q <= word_count_q[ADDR_W-1:0];
                     mem_wr_data_q <= in_data;
                     sum_q         <= sum_d;
                     word_count_q  <= word_count_d;
                  end else begin
                     // Overflow is flagged on the accepting edge itself.
                     in_ready_q <= 1'b0;
                     error_q    <= 1'b1;
                     state_q    <= ST_ERROR;
                  end
               end
            end
            ST_CHECK: begin
               state_q <= (sum_q == chk_q) ? ST_RUN : ST_ERROR;
            end
            default: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign mem_wr_en   = mem_wr_en_q;
   assign mem_wr_addr = mem_wr_addr_q;
   assign mem_wr_data = mem_wr_data_q;
   assign core_run    = core_run_q;
   assign done        = done_q;
   assign error       = error_q;
   assign word_count  = word_count_q;
   assign dbg_state   = state_q;

endmodule
